// File: rtl/bsg_link_packet_deframer.sv
// rtl/bsg_link_packet_deframer.sv - frames the link flit stream into header/body packets
// Oversized packets are dropped; one registered output slot drives the core side.
module bsg_link_packet_deframer #(
  parameter int width_p         = 16,
  parameter int len_width_p     = 8,
  parameter int max_len_p       = 2**len_width_p-1,
  parameter int counter_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       yumi_o,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  output logic                       first_o,
  output logic                       last_o,
  input  logic                       ready_and_i,
  output logic [counter_width_p-1:0] pkt_count_o,
  output logic [counter_width_p-1:0] drop_count_o
);

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] body_s = 2'd1;
  localparam logic [1:0] drop_s = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [len_width_p-1:0]     cnt_q, cnt_d;
  logic [width_p-1:0]         data_q, data_d;
  logic                       v_q, v_d;
  logic                       first_q, first_d;
  logic                       last_q, last_d;
  logic [counter_width_p-1:0] pkt_q, pkt_d;
  logic [counter_width_p-1:0] drop_q, drop_d;

  logic [len_width_p-1:0] hdr_len;
  logic                   hdr_illegal;
  logic                   out_free;
  logic                   last_body;

  assign hdr_len     = data_i[len_width_p-1:0];
  assign hdr_illegal = (int'(hdr_len) > max_len_p);
  assign out_free    = !v_q || ready_and_i;
  assign last_body   = (cnt_q == len_width_p'(1));

  // Dropped flits never touch the output slot, so DROP does not wait on it.
  assign yumi_o = (state_q == drop_s) ? v_i : (v_i && out_free);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    v_d     = v_q && !ready_and_i;
    first_d = first_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    case (state_q)
      idle_s: begin
        if (yumi_o) begin
          if (hdr_illegal) begin
            drop_d  = (drop_q == '1) ? drop_q : drop_q + counter_width_p'(1);
            cnt_d   = hdr_len;
            state_d = (hdr_len != '0) ? drop_s : idle_s;
          end else begin
            data_d  = data_i;
            v_d     = 1'b1;
            first_d = 1'b1;
            if (hdr_len == '0) begin
              last_d = 1'b1;
              pkt_d  = pkt_q + counter_width_p'(1);
            end else begin
              last_d  = 1'b0;
              cnt_d   = hdr_len;
              state_d = body_s;
            end
          end
        end
      end
      body_s: begin
        if (yumi_o) begin
          data_d  = data_i;
          v_d     = 1'b1;
          first_d = 1'b0;
          last_d  = last_body;
          cnt_d   = cnt_q - len_width_p'(1);
          if (last_body) begin
            pkt_d   = pkt_q + counter_width_p'(1);
            state_d = idle_s;
          end
        end
      end
      drop_s: begin
        if (yumi_o) begin
          cnt_d = cnt_q - len_width_p'(1);
          if (last_body) state_d = idle_s;
        end
      end
      default: state_d = idle_s;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      cnt_q   <= '0;
      v_q     <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      first_q <= first_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
    end
  end

  // Payload register carries no reset; v_o qualifies it.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o       = data_q;
  assign v_o          = v_q;
  assign first_o      = first_q;
  assign last_o       = last_q;
  assign pkt_count_o  = pkt_q;
  assign drop_count_o = drop_q;

endmodule
